// File: rtl/mux_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mux_seq_pkg
// Description : Shared sizing constants and FSM state encoding for the
//               round-robin MUX8x1 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_seq_pkg;

    localparam int N_CH   = 8;
    localparam int SEL_W  = $clog2(N_CH);
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : mux_rr_sequencer_if
// Description : Groups the sequencer-facing request, mux and downstream
//               valid/ready signals.
//               req    - per-channel request lines
//               mux_in - MUX8x1 OUT fed back to the sequencer
//               s      - registered select driven to MUX8x1
//               gnt    - one-hot, one-cycle capture pulse
//               dout   - captured word, dch - its channel index
//               dvalid - dout/dch valid, dready - downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_sequencer_if;
    import mux_seq_pkg::*;

    logic [N_CH-1:0]   req;
    logic [DATA_W-1:0] mux_in;
    logic [SEL_W-1:0]  s;
    logic [N_CH-1:0]   gnt;
    logic [DATA_W-1:0] dout;
    logic [SEL_W-1:0]  dch;
    logic              dvalid;
    logic              dready;

    // Sequencer side
    modport master (
        input  req, mux_in, dready,
        output s, gnt, dout, dch, dvalid
    );

    // Environment side (requesters, mux and downstream consumer)
    modport slave (
        output req, mux_in, dready,
        input  s, gnt, dout, dch, dvalid
    );

endinterface
`default_nettype wire

// File: rtl/mux_rr_sequencer_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority search. Starting just after the
//               last-served pointer, returns the first requesting channel.
//               A lone request from the pointer channel itself is found last,
//               so it is still re-granted.
//               i_req    - request vector
//               i_ptr    - last-served channel
//               o_any    - at least one request present
//               o_winner - selected channel index (0 when o_any is low)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_seq_pkg::*;
#(
    parameter int P_N_CH  = N_CH,
    parameter int P_SEL_W = SEL_W
) (
    input  wire logic [P_N_CH-1:0]  i_req,
    input  wire logic [P_SEL_W-1:0] i_ptr,
    output logic                    o_any,
    output logic [P_SEL_W-1:0]      o_winner
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after i_ptr is the last (and winning) assignment. The index
    // sum wraps in P_SEL_W bits, which relies on P_N_CH being a power of two.
    always_comb begin
        o_any    = |i_req;
        o_winner = '0;
        for (int k = P_N_CH; k >= 1; k--) begin
            if (i_req[i_ptr + P_SEL_W'(k)]) begin
                o_winner = i_ptr + P_SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sequencer
// Description : Upstream control stage for an 8:1, 4-bit MUX8x1. Arbitrates
//               the request lines round-robin, drives the mux select, waits
//               one cycle for the mux to settle, captures its output and
//               offers the word downstream over valid/ready.
//               clk - rising-edge clock
//               rst - synchronous active-high reset
//               bus - mux_rr_sequencer_if.master (req, mux_in, dready in;
//                     s, gnt, dout, dch, dvalid out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sequencer
    import mux_seq_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    mux_rr_sequencer_if.master  bus
);

    // Pointer reset value: search after reset starts at channel 0.
    localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(N_CH - 1);

    state_t              r_state;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_s;
    logic [N_CH-1:0]     r_gnt;
    logic [DATA_W-1:0]   r_dout;
    logic [SEL_W-1:0]    r_dch;
    logic                r_dvalid;

    state_t              w_state_nxt;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [SEL_W-1:0]    w_s_nxt;
    logic [N_CH-1:0]     w_gnt_nxt;
    logic [DATA_W-1:0]   w_dout_nxt;
    logic [SEL_W-1:0]    w_dch_nxt;
    logic                w_dvalid_nxt;

    logic                w_any;
    logic [SEL_W-1:0]    w_winner;

    rr_pick #(
        .P_N_CH  (N_CH),
        .P_SEL_W (SEL_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= c_ptr_rst;
            r_s      <= '0;
            r_gnt    <= '0;
            r_dout   <= '0;
            r_dch    <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_s      <= w_s_nxt;
            r_gnt    <= w_gnt_nxt;
            r_dout   <= w_dout_nxt;
            r_dch    <= w_dch_nxt;
            r_dvalid <= w_dvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_s_nxt      = r_s;
        w_gnt_nxt    = '0;          // grant is a single-cycle pulse
        w_dout_nxt   = r_dout;
        w_dch_nxt    = r_dch;
        w_dvalid_nxt = r_dvalid;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_s_nxt     = w_winner;
                    w_state_nxt = SELECT;
                end
            end
            SELECT: begin
                // Select held a full cycle so the mux output is settled.
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // Captured regardless of whether the request is still up.
                w_dout_nxt       = bus.mux_in;
                w_dch_nxt        = r_s;
                w_dvalid_nxt     = 1'b1;
                w_gnt_nxt[r_s]   = 1'b1;
                w_ptr_nxt        = r_s;
                w_state_nxt      = HOLD;
            end
            HOLD: begin
                if (r_dvalid && bus.dready) begin
                    w_dvalid_nxt = 1'b0;
                    // Re-arbitrate in the transfer cycle to keep the
                    // three-cycle word rate.
                    if (w_any) begin
                        w_s_nxt     = w_winner;
                        w_state_nxt = SELECT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.s      = r_s;
    assign bus.gnt    = r_gnt;
    assign bus.dout   = r_dout;
    assign bus.dch    = r_dch;
    assign bus.dvalid = r_dvalid;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_sequencer
// Description : Self-checking bench for mux_rr_sequencer. The MUX8x1 is
//               modelled inline (mux_in = a[s]) to close the select/output
//               loop. A transaction-level reference tracks pointer, pending
//               capture distance and the held word, and every cycle is
//               compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sequencer;
    import mux_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_sequencer_if bus ();

    logic [3:0] a [8];
    assign bus.mux_in = a[bus.s];

    mux_rr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state
    logic [2:0] m_ptr;
    logic [2:0] m_s;
    logic [2:0] m_dch;
    logic [7:0] m_gnt;
    logic [3:0] m_dout;
    logic       m_dvalid;
    int         m_pending;   // cycles until capture: 2, 1, or 0 (none)

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // First requester strictly after p, wrapping, ending at p itself.
    function automatic logic [2:0] rr_next(input logic [2:0] p, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
        end
        return 3'd0;
    endfunction

    // Advances the reference across one rising edge using current inputs.
    task automatic model_edge();
        logic xfer;
        if (rst) begin
            m_ptr = 3'd7; m_s = 3'd0; m_dch = 3'd0; m_gnt = 8'd0;
            m_dout = 4'd0; m_dvalid = 1'b0; m_pending = 0;
        end else begin
            xfer  = m_dvalid && bus.dready;
            m_gnt = 8'd0;
            if (m_pending == 1) begin
                m_dout    = a[m_s];
                m_dch     = m_s;
                m_dvalid  = 1'b1;
                m_gnt     = 8'd1 << m_s;
                m_ptr     = m_s;
                m_pending = 0;
            end else if (m_pending == 2) begin
                m_pending = 1;
            end else if (!m_dvalid || xfer) begin
                if (xfer) m_dvalid = 1'b0;
                if (|bus.req) begin
                    m_s       = rr_next(m_ptr, bus.req);
                    m_pending = 2;
                end
            end
        end
    endtask

    task automatic step(input logic [7:0] rq, input logic rd, input logic rs);
        bus.req    = rq;
        bus.dready = rd;
        rst        = rs;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("s",      32'(bus.s),      32'(m_s));
        check_eq("gnt",    32'(bus.gnt),    32'(m_gnt));
        check_eq("dvalid", 32'(bus.dvalid), 32'(m_dvalid));
        check_eq("dout",   32'(bus.dout),   32'(m_dout));
        check_eq("dch",    32'(bus.dch),    32'(m_dch));
    endtask

    initial begin
        int n;
        m_ptr = 3'd7; m_s = 3'd0; m_dch = 3'd0; m_gnt = 8'd0;
        m_dout = 4'd0; m_dvalid = 1'b0; m_pending = 0;
        for (int i = 0; i < 8; i++) a[i] = 4'($urandom);

        // Reset with all requests asserted
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);

        // Single request on channel 2
        a[2] = 4'b0011;
        step(8'b0000_0100, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b0);

        // Full round robin with wrap
        for (int i = 0; i < 8; i++) a[i] = 4'(i + 1);
        for (int i = 0; i < 30; i++) step(8'hFF, 1'b1, 1'b0);

        // Backpressure
        n = 0;
        while (!m_dvalid && n < 6) begin step(8'hFF, 1'b1, 1'b0); n++; end
        for (int i = 0; i < 5; i++) step(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b0);

        // Wrap/priority: serve ch6, then ch0 before ch6, then lone ch6
        step(8'b0100_0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'b0100_0001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'b0100_0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0);

        // Reset during the capture cycle
        n = 0;
        while (m_pending != 1 && n < 8) begin step(8'hFF, 1'b1, 1'b0); n++; end
        check_eq("reach_capture", 32'(m_pending), 32'd1);
        step(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(8'hFF, 1'b1, 1'b0);

        // Randomised traffic, backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rq;
            rq = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & $urandom);
            a[$urandom_range(0, 7)] = 4'($urandom);
            step(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
